// File: rtl/structs_pkg.sv
// Shared front-end types: the fetch-stage packet, the fetch queue depth and its control FSM states.
package structs_pkg;

    localparam int FQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
        logic [3:0]  ras_ptr;
        logic [31:0] jalr_address;
        logic [3:0]  mcause;
        logic        exception;
    } pipe_in_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fq_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between fetch and decode with commit-driven flush and a
// hold state that stops enqueueing once an excepting packet has entered.
module fetch_queue
    import structs_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  pipe_in_t               pipe_in,
    input  logic                   mispredicted,
    input  logic                   exception,
    input  logic                   mret,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output pipe_in_t               deq_data,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pipe_in_t             mem_q [DEPTH];
    logic     [PTR_W-1:0] head_q, head_d;
    logic     [PTR_W-1:0] tail_q, tail_d;
    logic     [CNT_W-1:0] count_q, count_d;
    fq_state_t            state_q, state_d;

    logic flush;
    logic full;
    logic hold;
    logic enq;
    logic deq;

    assign flush = mispredicted | exception | mret;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign hold  = (state_q == HOLD);

    // Full blocks enqueue even when a dequeue frees a slot in the same cycle.
    assign enq = !flush && !full && !hold;
    assign deq_valid = (count_q != '0) && !flush;
    assign deq = deq_valid && deq_ready;

    assign deq_data = mem_q[head_q];
    assign count    = count_q;
    // Released during a flush so fetch can take the redirect immediately.
    assign stall    = (full || hold) && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            case (state_q)
                RUN:     if (enq && pipe_in.exception) state_d = HOLD;
                HOLD:    state_d = HOLD;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Storage is data only; reset leaves contents alone since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            mem_q[tail_q] <= pipe_in;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue with a queue-based reference model and scoreboard.
module tb_fetch_queue;
    import structs_pkg::*;

    localparam int DEPTH = FQ_DEPTH;

    logic                   clk;
    logic                   reset;
    pipe_in_t               pipe_in;
    logic                   mispredicted;
    logic                   exception;
    logic                   mret;
    logic                   deq_ready;
    logic                   deq_valid;
    pipe_in_t               deq_data;
    logic                   stall;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(FQ_DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pipe_in(pipe_in),
        .mispredicted(mispredicted),
        .exception(exception),
        .mret(mret),
        .deq_ready(deq_ready),
        .deq_valid(deq_valid),
        .deq_data(deq_data),
        .stall(stall),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected contents in FIFO order, occupancy and hold flag.
    pipe_in_t sb[$];
    int       mcount  = 0;
    bit       mhold   = 1'b0;
    bit       started = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pipe_in_t mk(input logic [31:0] pc, input logic exc, input logic [3:0] mc);
        pipe_in_t p;
        p.pc           = pc;
        p.instruction  = $urandom;
        p.prediction   = 1'($urandom_range(1));
        p.branch       = 1'($urandom_range(1));
        p.jump         = 1'($urandom_range(1));
        p.ras_ptr      = 4'($urandom_range(15));
        p.jalr_address = $urandom;
        p.mcause       = mc;
        p.exception    = exc;
        return p;
    endfunction

    always @(posedge clk) begin
        bit fl;
        bit e;
        bit d;
        fl = mispredicted || exception || mret;
        if (reset) begin
            sb.delete();
            mcount  <= 0;
            mhold   <= 1'b0;
            started <= 1'b1;
        end else if (started) begin
            if (fl) begin
                sb.delete();
                mcount <= 0;
                mhold  <= 1'b0;
            end else begin
                e = (mcount < DEPTH) && !mhold;
                d = (mcount > 0) && deq_ready;
                if (e) begin
                    sb.push_back(pipe_in);
                    if (pipe_in.exception) mhold <= 1'b1;
                end
                mcount <= mcount + int'(e) - int'(d);
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        bit fl;
        pipe_in_t exp_p;
        if (started) begin
            fl = mispredicted || exception || mret;
            chk("deq_valid", 128'(deq_valid), 128'((mcount != 0) && !fl));
            chk("count", 128'(count), 128'(mcount));
            chk("stall", 128'(stall), 128'(((mcount == DEPTH) || mhold) && !fl));
            if (deq_valid && deq_ready && !fl) begin
                if (sb.size() == 0) begin
                    chk("deq_underflow", 128'(1), 128'(0));
                end else begin
                    exp_p = sb.pop_front();
                    chk("deq_data", 128'(deq_data), 128'(exp_p));
                end
            end
        end
    end

    task automatic step(input pipe_in_t p, input logic mis_i, input logic exc_i,
                        input logic mret_i, input logic rdy_i, input logic rst_i);
        pipe_in      = p;
        mispredicted = mis_i;
        exception    = exc_i;
        mret         = mret_i;
        deq_ready    = rdy_i;
        reset        = rst_i;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mispredicted = 1'b0;
        exception    = 1'b0;
        mret         = 1'b0;
        deq_ready    = 1'b0;
        reset        = 1'b0;
        #1;
    endtask

    initial begin
        pipe_in      = '0;
        mispredicted = 1'b0;
        exception    = 1'b0;
        mret         = 1'b0;
        deq_ready    = 1'b0;
        reset        = 1'b1;
        step(mk(32'h0, 1'b0, 4'h0), 0, 0, 0, 0, 1);
        step(mk(32'h0, 1'b0, 4'h0), 0, 0, 0, 0, 1);
        quiet();
        chk("reset_count", 128'(count), 128'(0));
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_valid", 128'(deq_valid), 128'(0));

        // Fill to full; the ninth packet is presented while full and must be dropped.
        for (int i = 0; i < 9; i++) step(mk(32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 0, 0);
        chk("fill_count", 128'(count), 128'(8));
        chk("fill_stall", 128'(stall), 128'(1));

        // Drain: the original eight come out in order; the monitor checks each pc.
        for (int i = 0; i < 8; i++) step(mk(32'h100 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 1, 0);
        step(mk(32'h0, 1'b0, 4'h0), 1, 0, 0, 1, 0);

        // Build occupancy 4 then enqueue and dequeue together for 10 cycles.
        for (int i = 0; i < 4; i++) step(mk(32'h400 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(mk(32'h500 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 1, 0);
        chk("concurrent_count", 128'(count), 128'(4));

        // Mispredict flush at occupancy 5 with deq_ready high.
        step(mk(32'h0, 1'b0, 4'h0), 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(mk(32'h600 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 0, 0);
        chk("preflush_count", 128'(count), 128'(5));
        step(mk(32'h700, 1'b0, 4'h0), 1, 0, 0, 1, 0);
        quiet();
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(deq_valid), 128'(0));
        chk("flush_stall", 128'(stall), 128'(0));

        // Exception packet enters and blocks later packets until an exception flush.
        step(mk(32'h800, 1'b1, 4'h2), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(mk(32'h900 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 0, 0);
        chk("hold_stall", 128'(stall), 128'(1));
        chk("hold_count", 128'(count), 128'(1));
        chk("hold_mcause", 128'(deq_data.mcause), 128'(4'h2));
        step(mk(32'ha00, 1'b0, 4'h0), 0, 1, 0, 0, 0);
        quiet();
        chk("exc_flush_stall", 128'(stall), 128'(0));
        chk("exc_flush_count", 128'(count), 128'(0));

        // Reset together with mret at occupancy 6.
        for (int i = 0; i < 6; i++) step(mk(32'hb00 + 32'(i * 4), 1'b0, 4'h0), 0, 0, 0, 0, 0);
        chk("prereset_count", 128'(count), 128'(6));
        step(mk(32'hc00, 1'b0, 4'h0), 0, 0, 1, 1, 1);
        quiet();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_head", 128'(dut.head_q), 128'(0));
        chk("rst_tail", 128'(dut.tail_q), 128'(0));
        chk("rst_fsm", 128'(dut.state_q), 128'(RUN));
        step(mk(32'hd00, 1'b0, 4'h0), 0, 0, 0, 0, 0);
        chk("post_rst_slot0", 128'(dut.mem_q[0].pc), 128'(32'hd00));
        chk("post_rst_tail", 128'(dut.tail_q), 128'(1));

        // Random traffic with occasional flushes, exceptions and resets.
        for (int i = 0; i < 800; i++) begin
            step(mk($urandom, 1'($urandom_range(31) == 0), 4'($urandom_range(15))),
                 1'($urandom_range(29) == 0), 1'($urandom_range(59) == 0),
                 1'($urandom_range(59) == 0), 1'($urandom_range(1)),
                 1'($urandom_range(199) == 0));
        end
        quiet();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
